// File: rtl/param_step_ctrl.sv
// -----------------------------------------------------------------------------
// param_step_ctrl
//
// Purpose:
//   Button-driven stepper for one entry of the Mode7 parameter bank. Two raw
//   push-buttons (plus/minus) are synchronised and debounced. A free-running
//   divider produces a one-cycle tick every DIV cycles. On each tick, if exactly
//   one debounced button is held, the current parameter (value_in) is moved by
//   +STEP or -STEP in sign-magnitude arithmetic. The result is registered into
//   value_out together with a one-cycle write strobe (value_we).
//
// Number format (value_in / value_out), sign-magnitude 24 bit:
//   [23] sign, [22:8] integer part, [7:0] fraction
//
// Configuration macro:
//   PSC_SATURATE_EN  defined   : same-sign magnitude overflow clamps to 23'h7FFFFF
//                    undefined : magnitude wraps modulo 2^23 (default build)
//
// Parameters:
//   DIV        tick period in clk cycles (>= 2)
//   DB_CYCLES  stable cycles required before a debounced level changes (>= 1)
//   STEP       step magnitude, unsigned, <= 24'h7FFFFF
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   btn_plus   in   raw asynchronous button
//   btn_minus  in   raw asynchronous button
//   value_in   in   [23:0] current parameter from the register file
//   value_out  out  [23:0] stepped value
//   value_we   out  one-cycle write strobe for value_out
//   db_plus    out  debounced level of btn_plus
//   db_minus   out  debounced level of btn_minus
//   tick       out  one-cycle pulse every DIV cycles
//
// Handshake: value_we is a pure strobe with no back-pressure. The register
// file must capture value_out in the cycle value_we is high; value_out only
// changes on the same edge that raises value_we.
// -----------------------------------------------------------------------------

// Two-flop synchroniser followed by a run-length debounce counter. The level
// flips only after the synchronised input has disagreed with it for DB_CYCLES
// consecutive cycles; any cycle of agreement restarts the count.
module psc_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module param_step_ctrl #(
    parameter int          DIV       = 1000000,
    parameter int          DB_CYCLES = 500000,
    parameter logic [23:0] STEP      = 24'h000100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_plus,
    input  logic        btn_minus,
    input  logic [23:0] value_in,
    output logic [23:0] value_out,
    output logic        value_we,
    output logic        db_plus,
    output logic        db_minus,
    output logic        tick
);
    localparam int TW = $clog2(DIV);
    localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);
    // tick is registered, so it is armed one count early to be high exactly
    // while the counter sits at DIV-1.
    localparam logic [TW-1:0] DIV_ARM  = TW'(DIV - 2);

    // ------------------------------------------------------------------
    // Debounce, one identical instance per button
    // ------------------------------------------------------------------
    psc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_plus (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_plus),
        .level (db_plus)
    );

    psc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_minus (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_minus),
        .level (db_minus)
    );

    // ------------------------------------------------------------------
    // Free-running tick divider
    // ------------------------------------------------------------------
    logic [TW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            tick    <= (div_cnt == DIV_ARM);
        end
    end

    // ------------------------------------------------------------------
    // Sign-magnitude sum of value_in and the signed step
    // ------------------------------------------------------------------
    logic        step_up;     // exactly one button, and it is plus
    logic        step_valid;  // exactly one button held
    logic        sign_a;
    logic        sign_b;
    logic [22:0] mag_a;
    logic [22:0] mag_b;
    logic [23:0] add_full;
    logic [22:0] res_mag;
    logic        res_sign;
    logic [23:0] sum_val;

    assign step_valid = db_plus ^ db_minus;
    assign step_up    = db_plus & ~db_minus;

    always_comb begin
        mag_a    = value_in[22:0];
        // A negative zero input is folded to +0 before the sign compare.
        sign_a   = value_in[23] & (value_in[22:0] != 23'd0);
        mag_b    = STEP[22:0];
        sign_b   = ~step_up;
        add_full = 24'd0;
        res_mag  = 23'd0;
        res_sign = 1'b0;

        if (sign_a == sign_b) begin
            add_full = {1'b0, mag_a} + {1'b0, mag_b};
            res_sign = sign_a;
`ifdef PSC_SATURATE_EN
            res_mag  = add_full[23] ? 23'h7FFFFF : add_full[22:0];
`else
            res_mag  = add_full[22:0];
`endif
        end else if (mag_a >= mag_b) begin
            res_mag  = mag_a - mag_b;
            res_sign = sign_a;
        end else begin
            res_mag  = mag_b - mag_a;
            res_sign = sign_b;
        end

        // No negative zero on the output.
        sum_val = (res_mag == 23'd0) ? 24'h000000 : {res_sign, res_mag};
    end

    // ------------------------------------------------------------------
    // Step decision and registered write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_out <= 24'h000000;
            value_we  <= 1'b0;
        end else begin
            if (tick && step_valid) begin
                value_out <= sum_val;
                value_we  <= 1'b1;
            end else begin
                value_we  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_param_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_param_step_ctrl
//
// Bench for param_step_ctrl with DIV=8, DB_CYCLES=4, STEP=1.0. A reference
// model works from the behavioural rules: the tick comes from the edge count
// since reset, a debounced level flips once the last DB_CYCLES raw samples
// (seen through the two-cycle synchroniser delay) all disagree with it, and
// the stepped value is computed with signed integer arithmetic. DUT outputs
// are compared with the model at every falling edge; directed scenarios add
// constant expectations on top.
// -----------------------------------------------------------------------------
module tb_param_step_ctrl;
    localparam int          DIV       = 8;
    localparam int          DB_CYCLES = 4;
    localparam logic [23:0] STEP      = 24'h000100;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_plus = 1'b0;
    logic        btn_minus = 1'b0;
    logic [23:0] value_in = 24'h0;
    logic [23:0] value_out;
    logic        value_we;
    logic        db_plus;
    logic        db_minus;
    logic        tick;

    always #5 clk = ~clk;

    param_step_ctrl #(
        .DIV       (DIV),
        .DB_CYCLES (DB_CYCLES),
        .STEP      (STEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_plus  (btn_plus),
        .btn_minus (btn_minus),
        .value_in  (value_in),
        .value_out (value_out),
        .value_we  (value_we),
        .db_plus   (db_plus),
        .db_minus  (db_minus),
        .tick      (tick)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int          m_edges;     // rising edges since reset release
    bit          m_tick, m_plus, m_minus, m_we;
    logic [23:0] m_out;
    bit          hp[$];       // raw btn_plus sample at each edge
    bit          hm[$];

    function automatic logic [23:0] ref_step(input logic [23:0] v, input bit up);
        int a, r, m;
        a = int'(v[22:0]);
        if (v[23]) a = -a;
        r = up ? a + int'(STEP) : a - int'(STEP);
        m = (r < 0) ? -r : r;
        if (m > 32'h7FFFFF) begin
`ifdef PSC_SATURATE_EN
            m = 32'h7FFFFF;
`else
            m = m % (1 << 23);
`endif
        end
        if (m == 0) return 24'h000000;
        return {(r < 0) ? 1'b1 : 1'b0, m[22:0]};
    endfunction

    // Level after this edge: flips when the DB_CYCLES samples ending two
    // edges ago all disagree with the current level.
    function automatic bit db_next(input bit lvl, input bit which);
        bit flip;
        bit s;
        int e;
        flip = 1'b1;
        for (int k = 0; k < DB_CYCLES; k++) begin
            e = m_edges - 2 - k;
            s = 1'b0;
            if (e >= 1) s = which ? hm[e-1] : hp[e-1];
            if (s == lvl) flip = 1'b0;
        end
        return flip ? ~lvl : lvl;
    endfunction

    task automatic model_clear();
        m_edges = 0;
        m_tick  = 0;
        m_plus  = 0;
        m_minus = 0;
        m_we    = 0;
        m_out   = 24'h0;
        hp.delete();
        hm.delete();
    endtask

    always @(posedge clk) begin
        if (reset) begin
            if (m_tick && (m_plus != m_minus)) begin
                m_out = ref_step(value_in, m_plus);
                m_we  = 1;
            end else begin
                m_we  = 0;
            end
            m_edges++;
            m_tick = ((m_edges % DIV) == DIV - 1);
            hp.push_back(btn_plus);
            hm.push_back(btn_minus);
            m_plus  = db_next(m_plus, 1'b0);
            m_minus = db_next(m_minus, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (reset && chk_en) begin
            check("tick",      {31'd0, tick},     {31'd0, m_tick});
            check("db_plus",   {31'd0, db_plus},  {31'd0, m_plus});
            check("db_minus",  {31'd0, db_minus}, {31'd0, m_minus});
            check("value_we",  {31'd0, value_we}, {31'd0, m_we});
            check("value_out", {8'd0, value_out}, {8'd0, m_out});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drive(input bit p, input bit m, input logic [23:0] v, input int cycles);
        @(negedge clk);
        btn_plus  = p;
        btn_minus = m;
        value_in  = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic release_all();
        drive(1'b0, 1'b0, value_in, 2 * DB_CYCLES + 4);
    endtask

    // Waits for the next write strobe and checks the written value.
    task automatic wait_we(input string tag, input logic [23:0] exp);
        bit seen;
        seen = 0;
        for (int k = 0; k < 4 * DIV && !seen; k++) begin
            @(negedge clk);
            if (value_we) seen = 1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
        else       check(tag, {8'd0, value_out}, {8'd0, exp});
    endtask

    // Presses btn_plus at a falling edge and counts cycles until db_plus rises.
    task automatic plus_latency(input string tag);
        int cyc;
        cyc = 0;
        btn_plus = 1'b1;
        while (!db_plus && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, cyc, DB_CYCLES + 2);
    endtask

    // ---------------- stimulus ----------------
    logic [23:0] pool [8];
    int          we_cnt;

    initial begin
        pool[0] = 24'h000000; pool[1] = 24'h800000; pool[2] = 24'h7FFFFF;
        pool[3] = 24'hFFFFFF; pool[4] = 24'h000100; pool[5] = 24'h800100;
        pool[6] = 24'h0000FF; pool[7] = 24'h8000FF;

        model_clear();
        #1;
        check("rst_value_out", {8'd0, value_out}, 32'd0);
        check("rst_value_we",  {31'd0, value_we}, 32'd0);
        check("rst_tick",      {31'd0, tick},     32'd0);
        check("rst_db",        {30'd0, db_plus, db_minus}, 32'd0);
        apply_reset();
        chk_en = 1'b1;

        // Idle: only ticks, no writes.
        drive(1'b0, 1'b0, 24'h000000, 30);

        // Plus from 3.0, with debounce latency measured.
        value_in = 24'h000300;
        plus_latency("plus_latency");
        wait_we("plus_3p0", 24'h000400);
        release_all();

        // Minus from 0.5 crosses zero, then plus from -0.5 crosses back.
        drive(1'b0, 1'b1, 24'h000080, 0);
        wait_we("minus_0p5", 24'h800080);
        release_all();
        drive(1'b1, 1'b0, 24'h800080, 0);
        wait_we("plus_neg0p5", 24'h000080);
        release_all();

        // Exact cancellation gives +0.
        drive(1'b0, 1'b1, 24'h000100, 0);
        wait_we("minus_to_zero", 24'h000000);
        release_all();

        // Negative zero input treated as +0.
        drive(1'b1, 1'b0, 24'h800000, 0);
        wait_we("negzero_plus", 24'h000100);
        release_all();

        // Both buttons held: no writes.
        we_cnt = 0;
        @(negedge clk);
        btn_plus = 1'b1; btn_minus = 1'b1;
        for (int k = 0; k < 5 * DIV; k++) begin
            @(negedge clk);
            if (value_we) we_cnt++;
        end
        check("both_no_we", we_cnt, 0);
        release_all();

        // Short glitch never reaches the debounced level.
        drive(1'b1, 1'b0, 24'h000000, DB_CYCLES - 1);
        we_cnt = 0;
        btn_plus = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (db_plus) we_cnt++;
        end
        check("glitch_db_plus", we_cnt, 0);

        // Magnitude overflow.
        drive(1'b1, 1'b0, 24'h7FFFFF, 0);
`ifdef PSC_SATURATE_EN
        wait_we("overflow_sat", 24'h7FFFFF);
`else
        wait_we("overflow_wrap", 24'h0000FF);
`endif
        release_all();

        // Reset in the middle of a hold clears levels at once.
        btn_plus = 1'b1;
        repeat (DB_CYCLES + 4) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("midrst_db_plus",   {31'd0, db_plus},   32'd0);
        check("midrst_value_out", {8'd0, value_out},  32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        plus_latency("midrst_latency");
        release_all();

        // Randomized segments.
        for (int seg = 0; seg < 250; seg++) begin
            logic [23:0] v;
            int          sel;
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) v = pool[$urandom_range(0, 7)];
            else                           v = 24'($urandom);
            drive(sel[0], sel[1], v, $urandom_range(1, 3 * DIV));
        end
        release_all();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
